// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch resolution with redirect target and 2-bit BHT
module branch_resolve_unit #(
  parameter int XLEN = 32,
  parameter int BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      br_type,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] br_op1,
  input  logic [XLEN-1:0] br_op2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] target_base,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mispredict,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken
);
  localparam int IDX = $clog2(BHT_ENTRIES);
  logic            eq, lt, ltu, taken_c, accept, retire;
  logic [XLEN-1:0] target_c;
  logic [IDX-1:0]  idx_q;
  logic [2:0]      type_q;
  logic [1:0]      bht [BHT_ENTRIES];
  logic            unused_lookup_bits;
  always_comb begin
    eq       = br_op1 == br_op2;
    lt       = $signed(br_op1) < $signed(br_op2);
    ltu      = br_op1 < br_op2;
    taken_c  = br_type == 3'd6 ? 1'b1 :
               br_type == 3'd7 ? 1'b0 :
               br_type[2]      ? ltu ^ br_type[0] :
               br_type[1]      ? lt ^ br_type[0] : eq ^ br_type[0];
    target_c = (target_base + imm) & {{(XLEN-1){1'b1}}, ~is_jalr};
    accept   = in_valid && in_ready && !flush;
    retire   = out_valid && out_ready && !flush;
  end
  assign in_ready           = !out_valid || out_ready;
  assign lookup_taken       = bht[lookup_pc[IDX+1:2]][1];
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX+2], lookup_pc[1:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      br_taken    <= 1'b0;
      br_target   <= '0;
      redirect_pc <= '0;
      mispredict  <= 1'b0;
      idx_q       <= '0;
      type_q      <= 3'd7;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      br_taken    <= taken_c;
      br_target   <= target_c;
      redirect_pc <= taken_c ? target_c : pc + XLEN'(4);
      mispredict  <= taken_c != pred_taken;
      idx_q       <= pc[IDX+1:2];
      type_q      <= br_type;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
    end else if (retire && type_q < 3'd6) begin
      bht[idx_q] <= br_taken ? (bht[idx_q] == 2'd3 ? 2'd3 : bht[idx_q] + 2'd1)
                             : (bht[idx_q] == 2'd0 ? 2'd0 : bht[idx_q] - 2'd1);
    end
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined, parametrised branch resolution unit for the pipelined RV32/RV64 core. It generalises the single-cycle branch-condition logic in three ways: configurable operand width, a registered valid/ready result stage, and redirect-target computation. It also owns a direct-mapped table of 2-bit saturating branch predictors. It sits at the end of execute: it accepts one branch/jump per cycle, resolves it one cycle later, and flags mispredictions to the fetch unit. Fetch uses the combinational lookup port for next-PC prediction.

## Interface
- XLEN, 32, operand/PC width (32 or 64)
- BHT_ENTRIES, 64, number of predictor counters; power of 2, ≥ 2; IDX = log2(BHT_ENTRIES)
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request
- br_type  in  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL/JALR (always taken), 7 not-a-branch
- is_jalr  in  1  clear bit 0 of computed target
- br_op1, br_op2  in  XLEN  compare operands
- pc  in  XLEN  PC of the instruction
- target_base  in  XLEN  pc for branch/JAL, rs1 for JALR
- imm  in  XLEN  sign-extended offset
- pred_taken  in  1  prediction fetch made for this instruction
- flush  in  1  kill held result and current request
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- br_taken  out  1  resolved direction
- br_target  out  XLEN  target_base + imm, bit 0 cleared if is_jalr
- redirect_pc  out  XLEN  br_taken ? br_target : pc + 4
- mispredict  out  1  br_taken != pred_taken
- lookup_pc  in  XLEN  fetch PC to predict
- lookup_taken  out  1  MSB of counter indexed by lookup_pc[IDX+1:2]

## Operation
- Compare: signed compare for types 2/3, unsigned for 4/5, equality for 0/1. Type 6 gives taken=1; type 7 gives taken=0.
- Arithmetic is modulo 2^XLEN. target and pc+4 wrap silently.
- Accept: in_valid && in_ready && !flush. Taken, target, redirect and mispredict are computed combinationally and registered together with pc and br_type.
- in_ready = !out_valid || out_ready. This is a single-entry pipeline register with full throughput and no skid buffer.
- Retire: out_valid && out_ready && !flush. If the registered br_type ≤ 5, update counter[pc[IDX+1:2]]: increment if taken, saturating at 3; decrement if not taken, saturating at 0. Types 6 and 7 never update the table.
- Flush: out_valid goes to 0 next cycle. A request presented in the same cycle is dropped. No table update occurs, even if out_ready=1.
- Lookup is a combinational read. When lookup and update hit the same index in the same cycle, lookup returns the pre-update value (no bypass).
- Reset: out_valid=0; br_taken, mispredict, br_target and redirect_pc = 0; all counters = CTR_INIT, so lookup_taken=0 after reset. Reset overrides flush and any in-progress handshake. A held result is discarded without a table update.

## Timing
- Latency is 1 cycle: a request accepted at edge N is visible on the outputs after edge N, with out_valid=1.
- Throughput is 1 per cycle while out_ready=1.
- When out_valid=1 and out_ready=0, all outputs hold stable and in_ready=0.
- Counter update takes effect at the retire edge and is visible on lookup_taken the following cycle.
- in_ready depends combinationally on out_ready. There is no combinational path from in_* to out_*.

## Test plan
- Reset, then lookup any PC → lookup_taken=0, out_valid=0. BLT with op1=0xFFFFFFFF, op2=1, pred_taken=0 → next cycle br_taken=1, mispredict=1.
- BLTU with the same operands → br_taken=0. With pc=0x100, redirect_pc=0x104.
- JALR: target_base=0x2001, imm=0x4, is_jalr=1 → br_target=0x2004, br_taken=1. BHT is unchanged.
- Training: BEQ at pc=0x40, equal operands, retired twice → lookup_pc=0x40 gives lookup_taken=1. Four not-taken retires → counter saturates at 0. A further not-taken retire keeps it at 0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release → the queued request is accepted the same cycle, back-to-back.
- Flush: assert flush with out_valid=1, out_ready=1 on a taken BNE → out_valid=0 next cycle and no counter change. A concurrently presented request is not accepted.
